// File: rtl/xbar_pkg.sv
// Shared definitions for the 4x4 crossbar slot scheduler.
// Latency: n/a (constants, types and a pure function only).
// Backpressure: n/a.
package xbar_pkg;

    localparam int PKT_W = 15;
    localparam int NPORT = 4;

    // Packet field layout; bits 13 and 10 are opaque and pass through.
    localparam int VLD_BIT = 14;
    localparam int DEST_HI = 12;
    localparam int DEST_LO = 11;
    localparam int SRC_HI  = 9;
    localparam int SRC_LO  = 8;
    localparam int PLD_HI  = 7;
    localparam int PLD_LO  = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        XFER = 2'd2
    } state_t;

    // Egress view of a granted head: the src field is stamped with the
    // winning input so downstream sees where the packet actually came from.
    function automatic logic [PKT_W-1:0] make_grant_pkt(
        input logic [PKT_W-1:0] head,
        input logic [1:0]       src
    );
        logic [PKT_W-1:0] p;
        p                 = head;
        p[VLD_BIT]        = 1'b1;
        p[SRC_HI:SRC_LO]  = src;
        return p;
    endfunction

endpackage

// File: rtl/rr_arb4.sv
// Four-requester round-robin arbiter, searching upward from ptr modulo 4.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the grant is used.
//
// Ports:
//   req[3:0]      request vector
//   ptr[1:0]      highest-priority requester index
//   gnt_valid     any request granted
//   gnt_idx[1:0]  index of the granted requester
//   gnt[3:0]      one-hot grant
module rr_arb4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       gnt_valid,
    output logic [1:0] gnt_idx,
    output logic [3:0] gnt
);

    logic [1:0] w_cand;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = 2'd0;
        gnt       = 4'd0;
        w_cand    = 2'd0;
        // 2-bit add wraps naturally, giving the modulo-4 search order.
        for (int k = 0; k < 4; k++) begin
            w_cand = ptr + 2'(k);
            if (!gnt_valid && req[w_cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = w_cand;
            end
        end
        if (gnt_valid) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/xbar_scheduler.sv
// Slot scheduler for the 4x4 crossbar: one head per input, per-output RR arbitration per slot.
// Latency: accept at edge E -> ARB at E+1 -> out_valid after E+2; minimum slot is 2 cycles.
// Backpressure: each output holds until its out_ready; slot ends when all grants drain; in_ready = ~head_valid.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   in_valid/in_ready[3:0]   ingress handshake per input
//   in_pkt0..3               ingress packets
//   out_valid/out_ready[3:0] egress handshake per output
//   out_pkt0..3              registered egress packets
//   busy                     FSM not in IDLE
//   slot_cnt                 completed slots, wrapping
module xbar_scheduler
    import xbar_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        in_valid,
    output logic [3:0]        in_ready,
    input  logic [PKT_W-1:0]  in_pkt0,
    input  logic [PKT_W-1:0]  in_pkt1,
    input  logic [PKT_W-1:0]  in_pkt2,
    input  logic [PKT_W-1:0]  in_pkt3,
    output logic [3:0]        out_valid,
    input  logic [3:0]        out_ready,
    output logic [PKT_W-1:0]  out_pkt0,
    output logic [PKT_W-1:0]  out_pkt1,
    output logic [PKT_W-1:0]  out_pkt2,
    output logic [PKT_W-1:0]  out_pkt3,
    output logic              busy,
    output logic [7:0]        slot_cnt
);

    state_t                          r_state;
    state_t                          w_state_nxt;

    logic [NPORT-1:0][PKT_W-1:0]     r_head;
    logic [NPORT-1:0]                r_head_vld;
    logic [NPORT-1:0][1:0]           r_rr_ptr;
    logic [NPORT-1:0][1:0]           r_sel;
    logic [NPORT-1:0]                r_out_vld;   // doubles as the live grant mask
    logic [NPORT-1:0][PKT_W-1:0]     r_out_pkt;
    logic [7:0]                      r_slot_cnt;

    logic [NPORT-1:0][PKT_W-1:0]     w_in_pkt;
    logic [NPORT-1:0]                w_acc;
    logic [NPORT-1:0]                w_store;
    logic [NPORT-1:0]                w_done;
    logic [NPORT-1:0]                w_clr;
    logic [NPORT-1:0]                w_head_vld_nxt;
    logic                            w_slot_end;

    logic [NPORT-1:0]                w_gnt_vld;
    logic [NPORT-1:0][1:0]           w_gnt_idx;
    logic [NPORT-1:0][PKT_W-1:0]     w_gnt_pkt;

    assign w_in_pkt = {in_pkt3, in_pkt2, in_pkt1, in_pkt0};

    // Ingress: a handshake always completes when the head is empty; packets
    // without the valid bit are swallowed so the source is never stalled.
    assign in_ready = ~r_head_vld;
    always_comb begin
        w_acc   = '0;
        w_store = '0;
        for (int i = 0; i < NPORT; i++) begin
            w_acc[i]   = in_valid[i] & ~r_head_vld[i];
            w_store[i] = w_acc[i] & w_in_pkt[i][VLD_BIT];
        end
    end

    // Per-output candidate selection and granted-packet formation.
    for (genvar g = 0; g < NPORT; g++) begin : g_out
        logic [NPORT-1:0] w_req;
        logic             w_gv;
        logic [1:0]       w_gi;
        logic [NPORT-1:0] w_g;
        logic [PKT_W-1:0] w_sel_pkt;

        always_comb begin
            w_req = '0;
            for (int i = 0; i < NPORT; i++) begin
                w_req[i] = r_head_vld[i] && (r_head[i][DEST_HI:DEST_LO] == 2'(g));
            end
        end

        rr_arb4 u_arb (
            .req       (w_req),
            .ptr       (r_rr_ptr[g]),
            .gnt_valid (w_gv),
            .gnt_idx   (w_gi),
            .gnt       (w_g)
        );

        // One-hot grant drives an AND-OR mux over the heads.
        always_comb begin
            w_sel_pkt = '0;
            for (int i = 0; i < NPORT; i++) begin
                if (w_g[i]) begin
                    w_sel_pkt = w_sel_pkt | r_head[i];
                end
            end
        end

        assign w_gnt_vld[g] = w_gv;
        assign w_gnt_idx[g] = w_gi;
        assign w_gnt_pkt[g] = w_gv ? make_grant_pkt(w_sel_pkt, w_gi) : '0;
    end

    // Delivery: an output completes on its own ready; ready on an ungranted
    // output is ignored because r_out_vld gates it.
    always_comb begin
        w_done = '0;
        w_clr  = '0;
        for (int o = 0; o < NPORT; o++) begin
            w_done[o] = (r_state == XFER) && r_out_vld[o] && out_ready[o];
            if (w_done[o]) begin
                w_clr[r_sel[o]] = 1'b1;
            end
        end
    end

    // A freed input cannot reload on the same edge (in_ready is low while
    // its head is valid), so clear and store never collide.
    assign w_head_vld_nxt = (r_head_vld & ~w_clr) | w_store;
    assign w_slot_end     = (r_state == XFER) && ((r_out_vld & ~w_done) == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Slot-end decision looks at next-cycle heads so a slot that just drained
    // its last head returns to IDLE instead of running an empty ARB.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (|r_head_vld) begin
                    w_state_nxt = ARB;
                end
            end
            ARB: begin
                w_state_nxt = XFER;
            end
            XFER: begin
                if (w_slot_end) begin
                    w_state_nxt = (|w_head_vld_nxt) ? ARB : IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head     <= '0;
            r_head_vld <= '0;
            r_rr_ptr   <= '0;
            r_sel      <= '0;
            r_out_vld  <= '0;
            r_out_pkt  <= '0;
            r_slot_cnt <= 8'd0;
        end else begin
            for (int i = 0; i < NPORT; i++) begin
                if (w_store[i]) begin
                    r_head[i] <= w_in_pkt[i];
                end
            end
            r_head_vld <= w_head_vld_nxt;

            if (r_state == ARB) begin
                for (int o = 0; o < NPORT; o++) begin
                    r_out_vld[o] <= w_gnt_vld[o];
                    r_sel[o]     <= w_gnt_idx[o];
                    r_out_pkt[o] <= w_gnt_pkt[o];
                end
            end

            for (int o = 0; o < NPORT; o++) begin
                if (w_done[o]) begin
                    r_out_vld[o] <= 1'b0;
                    r_rr_ptr[o]  <= r_sel[o] + 2'd1;
                end
            end

            if (w_slot_end) begin
                r_slot_cnt <= r_slot_cnt + 8'd1;
            end
        end
    end

    assign out_valid = r_out_vld;
    assign out_pkt0  = r_out_pkt[0];
    assign out_pkt1  = r_out_pkt[1];
    assign out_pkt2  = r_out_pkt[2];
    assign out_pkt3  = r_out_pkt[3];
    assign busy      = (r_state != IDLE);
    assign slot_cnt  = r_slot_cnt;

endmodule

// File: tb/tb_xbar_scheduler.sv
// Directed bench for xbar_scheduler: reset, single packet, contention/rotation,
// permutation, backpressure, invalid drop, reset mid-transfer.
module tb_xbar_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [14:0] in_pkt [4];
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [14:0] out_pkt [4];
    logic        busy;
    logic [7:0]  slot_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_slot;

    always #5 clk = ~clk;

    xbar_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pkt0   (in_pkt[0]),
        .in_pkt1   (in_pkt[1]),
        .in_pkt2   (in_pkt[2]),
        .in_pkt3   (in_pkt[3]),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pkt0  (out_pkt[0]),
        .out_pkt1  (out_pkt[1]),
        .out_pkt2  (out_pkt[2]),
        .out_pkt3  (out_pkt[3]),
        .busy      (busy),
        .slot_cnt  (slot_cnt)
    );

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle_timeout: busy=%b expected 0", name, busy);
        end
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        in_valid  = 4'h0;
        out_ready = 4'hF;
        for (int i = 0; i < 4; i++) in_pkt[i] = 15'h0;
        wait_n(2);
        checks++; if (out_valid !== 4'h0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0000", out_valid); end
        checks++; if (in_ready !== 4'hF) begin errors++; $display("FAIL rst_in_ready: got %b expected 1111", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (slot_cnt !== 8'd0) begin errors++; $display("FAIL rst_slot_cnt: got %0d expected 0", slot_cnt); end
        for (int o = 0; o < 4; o++) begin
            checks++; if (out_pkt[o] !== 15'h0) begin errors++; $display("FAIL rst_out_pkt%0d: got %h expected 0000", o, out_pkt[o]); end
        end
        rst = 1'b0;
        exp_slot = 8'd0;
        @(negedge clk);
    endtask

    task automatic test_single;
        in_pkt[0] = 15'h4A5C;
        in_valid  = 4'b0001;
        @(negedge clk);
        in_valid = 4'b0000;
        checks++; if (in_ready !== 4'b1110) begin errors++; $display("FAIL single_in_ready: got %b expected 1110", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_e: got %b expected 0", busy); end
        @(negedge clk);
        checks++; if (busy !== 1'b1 || out_valid !== 4'b0000) begin errors++; $display("FAIL single_arb: busy=%b out_valid=%b expected 1/0000", busy, out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 4'b0010) begin errors++; $display("FAIL single_out_valid: got %b expected 0010", out_valid); end
        checks++; if (out_pkt[1] !== 15'h485C) begin errors++; $display("FAIL single_out_pkt1: got %h expected 485c", out_pkt[1]); end
        checks++; if (out_pkt[0] !== 15'h0) begin errors++; $display("FAIL single_ungranted_pkt0: got %h expected 0000", out_pkt[0]); end
        @(negedge clk);
        exp_slot = exp_slot + 8'd1;
        checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL single_drop: got %b expected 0000", out_valid); end
        checks++; if (slot_cnt !== exp_slot) begin errors++; $display("FAIL single_slot_cnt: got %0d expected %0d", slot_cnt, exp_slot); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b expected 0", busy); end
        checks++; if (in_ready !== 4'hF) begin errors++; $display("FAIL single_in_ready_end: got %b expected 1111", in_ready); end
    endtask

    task automatic test_contention;
        logic [14:0] e;
        for (int i = 0; i < 4; i++) in_pkt[i] = 15'h5010 + 15'(i);
        in_valid = 4'hF;
        @(negedge clk);
        in_valid = 4'h0;
        wait_n(2);
        for (int s = 0; s < 4; s++) begin
            e = 15'h5010 | 15'(s) | (15'(s) << 8);
            checks++; if (out_valid !== 4'b0100) begin errors++; $display("FAIL cont_valid_s%0d: got %b expected 0100", s, out_valid); end
            checks++; if (out_pkt[2] !== e) begin errors++; $display("FAIL cont_pkt_s%0d: got %h expected %h", s, out_pkt[2], e); end
            if (s < 3) wait_n(2);
        end
        @(negedge clk);
        exp_slot = exp_slot + 8'd4;
        checks++; if (slot_cnt !== exp_slot) begin errors++; $display("FAIL cont_slot_cnt: got %0d expected %0d", slot_cnt, exp_slot); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cont_busy_end: got %b expected 0", busy); end
        // Pointer for output 2 must have wrapped to 0: input 0 beats input 3.
        in_pkt[0] = 15'h5040;
        in_pkt[3] = 15'h5043;
        in_valid  = 4'b1001;
        @(negedge clk);
        in_valid = 4'h0;
        wait_n(2);
        checks++; if (out_pkt[2] !== 15'h5040) begin errors++; $display("FAIL cont_ptr_wrap: got %h expected 5040", out_pkt[2]); end
        wait_n(2);
        checks++; if (out_pkt[2] !== 15'h5343) begin errors++; $display("FAIL cont_second: got %h expected 5343", out_pkt[2]); end
        wait_idle("cont");
        exp_slot = exp_slot + 8'd2;
        checks++; if (slot_cnt !== exp_slot) begin errors++; $display("FAIL cont_slot_cnt2: got %0d expected %0d", slot_cnt, exp_slot); end
    endtask

    task automatic test_permutation;
        logic [14:0] e [4];
        e[0] = 15'h43A3; e[1] = 15'h4AA2; e[2] = 15'h51A1; e[3] = 15'h58A0;
        for (int i = 0; i < 4; i++) in_pkt[i] = 15'h4000 | (15'(3 - i) << 11) | (15'h00A0 + 15'(i));
        in_valid = 4'hF;
        @(negedge clk);
        in_valid = 4'h0;
        @(negedge clk);
        checks++; if (busy !== 1'b1 || out_valid !== 4'h0) begin errors++; $display("FAIL perm_arb: busy=%b out_valid=%b expected 1/0000", busy, out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 4'hF) begin errors++; $display("FAIL perm_all_valid: got %b expected 1111", out_valid); end
        for (int o = 0; o < 4; o++) begin
            checks++; if (out_pkt[o] !== e[o]) begin errors++; $display("FAIL perm_pkt%0d: got %h expected %h", o, out_pkt[o], e[o]); end
        end
        @(negedge clk);
        exp_slot = exp_slot + 8'd1;
        checks++; if (out_valid !== 4'h0 || busy !== 1'b0) begin errors++; $display("FAIL perm_end: out_valid=%b busy=%b expected 0000/0", out_valid, busy); end
        checks++; if (slot_cnt !== exp_slot) begin errors++; $display("FAIL perm_slot_cnt: got %0d expected %0d", slot_cnt, exp_slot); end
    endtask

    task automatic test_backpressure;
        out_ready = 4'b1101;
        in_pkt[0] = 15'h4011;
        in_pkt[1] = 15'h4822;
        in_valid  = 4'b0011;
        @(negedge clk);
        in_valid = 4'h0;
        wait_n(2);
        checks++; if (out_valid !== 4'b0011) begin errors++; $display("FAIL bp_valid: got %b expected 0011", out_valid); end
        checks++; if (out_pkt[0] !== 15'h4011) begin errors++; $display("FAIL bp_pkt0: got %h expected 4011", out_pkt[0]); end
        checks++; if (out_pkt[1] !== 15'h4922) begin errors++; $display("FAIL bp_pkt1: got %h expected 4922", out_pkt[1]); end
        @(negedge clk);
        checks++; if (out_valid !== 4'b0010) begin errors++; $display("FAIL bp_out0_drop: got %b expected 0010", out_valid); end
        checks++; if (in_ready !== 4'b1101) begin errors++; $display("FAIL bp_in_ready: got %b expected 1101", in_ready); end
        // New head on input 0 must wait for the next ARB.
        in_pkt[0] = 15'h4033;
        in_valid  = 4'b0001;
        @(negedge clk);
        in_valid = 4'h0;
        for (int c = 0; c < 4; c++) begin
            checks++; if (out_valid !== 4'b0010 || out_pkt[1] !== 15'h4922 || busy !== 1'b1) begin
                errors++; $display("FAIL bp_hold_c%0d: out_valid=%b pkt1=%h busy=%b expected 0010/4922/1", c, out_valid, out_pkt[1], busy);
            end
            if (c < 3) @(negedge clk);
        end
        out_ready = 4'hF;
        @(negedge clk);
        exp_slot = exp_slot + 8'd1;
        checks++; if (out_valid !== 4'h0 || busy !== 1'b1) begin errors++; $display("FAIL bp_release: out_valid=%b busy=%b expected 0000/1", out_valid, busy); end
        checks++; if (slot_cnt !== exp_slot) begin errors++; $display("FAIL bp_slot_cnt: got %0d expected %0d", slot_cnt, exp_slot); end
        checks++; if (in_ready !== 4'b1110) begin errors++; $display("FAIL bp_in_ready2: got %b expected 1110", in_ready); end
        @(negedge clk);
        checks++; if (out_valid !== 4'b0001 || out_pkt[0] !== 15'h4033) begin errors++; $display("FAIL bp_next: out_valid=%b pkt0=%h expected 0001/4033", out_valid, out_pkt[0]); end
        wait_idle("bp");
        exp_slot = exp_slot + 8'd1;
        checks++; if (slot_cnt !== exp_slot) begin errors++; $display("FAIL bp_slot_cnt2: got %0d expected %0d", slot_cnt, exp_slot); end
    endtask

    task automatic test_invalid;
        in_pkt[2] = 15'h0A5C;
        in_valid  = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (in_ready[2] !== 1'b1 || busy !== 1'b0 || out_valid !== 4'h0) begin
                errors++; $display("FAIL inv_c%0d: in_ready2=%b busy=%b out_valid=%b expected 1/0/0000", c, in_ready[2], busy, out_valid);
            end
        end
        in_valid = 4'h0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_xfer;
        out_ready = 4'h0;
        in_pkt[2] = 15'h4055;
        in_pkt[3] = 15'h5066;
        in_valid  = 4'b1100;
        @(negedge clk);
        in_valid = 4'h0;
        wait_n(2);
        checks++; if (out_valid !== 4'b0101) begin errors++; $display("FAIL rmx_pre: got %b expected 0101", out_valid); end
        #1 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 4'h0 || in_ready !== 4'hF || busy !== 1'b0 || slot_cnt !== 8'd0) begin
            errors++; $display("FAIL rmx_async: out_valid=%b in_ready=%b busy=%b slot=%0d expected 0000/1111/0/0", out_valid, in_ready, busy, slot_cnt);
        end
        for (int o = 0; o < 4; o++) begin
            checks++; if (out_pkt[o] !== 15'h0) begin errors++; $display("FAIL rmx_pkt%0d: got %h expected 0000", o, out_pkt[o]); end
        end
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 4'hF;
        exp_slot  = 8'd0;
        @(negedge clk);
        // Output 0 pointer was 1 before reset; after reset input 0 must win.
        in_pkt[0] = 15'h4077;
        in_pkt[1] = 15'h4088;
        in_valid  = 4'b0011;
        @(negedge clk);
        in_valid = 4'h0;
        wait_n(2);
        checks++; if (out_valid !== 4'b0001 || out_pkt[0] !== 15'h4077) begin errors++; $display("FAIL rmx_ptr0: out_valid=%b pkt0=%h expected 0001/4077", out_valid, out_pkt[0]); end
        wait_idle("rmx");
        exp_slot = exp_slot + 8'd2;
        checks++; if (slot_cnt !== exp_slot) begin errors++; $display("FAIL rmx_slot_cnt: got %0d expected %0d", slot_cnt, exp_slot); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_permutation();
        test_backpressure();
        test_invalid();
        test_reset_mid_xfer();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
